// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit-side data path.
// Imported by the feeder and by the CRC16 byte engine.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CRC_LO,
    CRC_HI,
    WAIT_DONE
  } tx_feed_state_t;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [1:0]  PID_DATA        = 2'b11;

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte USB CRC16 update: eight LSB-first serial steps unrolled into one cycle.
// Purely combinational so the receive-side checker can reuse it.
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc;

  // NOTE: blocking assignments here chain the eight steps combinationally;
  // each iteration consumes the value produced by the previous one.
  always_comb begin
    crc = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      crc = crc[0] ? ((crc >> 1) ^ CRC16_POLY_REFL) : (crc >> 1);
    end
    crc_out = crc;
  end

endmodule

// File: rtl/usb_tx_data_feeder.sv
// Payload FIFO plus framing FSM that feeds the USB transmitter one byte per
// byte_req, then appends the complemented CRC16 low byte first.
module usb_tx_data_feeder
  import usb_tx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             tx_start,
  input  logic             byte_req,
  input  logic             tx_complete,
  output logic             tx_ena,
  output logic [1:0]       pid,
  output logic [7:0]       tx_byte,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  tx_feed_state_t   state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remaining_q, remaining_d;
  logic [15:0]      crc_q, crc_d, crc_next;
  logic             tx_ena_q, tx_ena_d, busy_q, busy_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       head;
  logic             wr_ok, pop;

  assign head  = mem_q[rd_ptr_q];
  assign wr_ok = wr_en && !full_q;

  usb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data    (head),
    .crc_out (crc_next)
  );

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    crc_d       = crc_q;
    overflow_d  = overflow_q;
    tx_ena_d    = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: if (tx_start) begin
        remaining_d = count_q;
        crc_d       = CRC16_INIT;
        tx_ena_d    = 1'b1;
        overflow_d  = 1'b0;
        state_d     = (count_q != '0) ? DATA : CRC_LO;
      end
      DATA: if (byte_req) begin
        pop         = 1'b1;
        crc_d       = crc_next;
        remaining_d = remaining_q - ONE_C;
        if (remaining_q == ONE_C) state_d = CRC_LO;
      end
      CRC_LO:    if (byte_req)    state_d = CRC_HI;
      CRC_HI:    if (byte_req)    state_d = WAIT_DONE;
      WAIT_DONE: if (tx_complete) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase

    // A write while full is lost even if a pop frees a slot this cycle.
    if (wr_en && full_q) overflow_d = 1'b1;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      crc_q       <= CRC16_INIT;
      tx_ena_q    <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      crc_q       <= crc_d;
      tx_ena_q    <= tx_ena_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers already discards its
  // contents, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    unique case (state_q)
      DATA:    tx_byte = head;
      CRC_LO:  tx_byte = ~crc_q[7:0];
      CRC_HI:  tx_byte = ~crc_q[15:8];
      default: tx_byte = 8'h00;
    endcase
  end

  assign tx_ena   = tx_ena_q;
  assign pid      = PID_DATA;
  assign busy     = busy_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
